// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for one single-ported memory; ARB_STARVE_GUARD_EN enables the fetch starvation guard
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } state_t;

    state_t state;
    logic   starve_hit;
    logic   grant_d;
    logic   grant_i;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts data grants that overtook a waiting fetch; bounded by STARVE_LIMIT
    // because reaching the limit with both pending forces a fetch grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d) begin
                starve_cnt <= i_req ? starve_cnt + CNT_W'(1) : '0;
            end
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        grant_d = d_req && !(i_req && starve_hit);
        grant_i = i_req && !grant_d;
    end

    // Valid pulses are raised on the ack edge so they are visible while in RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= BUSY_D;
                    end else if (grant_i) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= i_addr;
                        state    <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        i_rdata <= mem_rdata;
                        mem_req <= 1'b0;
                        i_valid <= 1'b1;
                        state   <= RESP;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        d_valid <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        bit          port_d;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_valid   (i_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit port_d, input logic [31:0] addr, input bit we,
                        input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.port_d = port_d;
        e.addr   = addr;
        e.we     = we;
        e.wdata  = wdata;
        e.rdata  = rdata;
        sb.push_back(e);
    endtask

    // Memory side of one transaction: wait for the grant, check the request
    // against the next scoreboard entry, ack after `delay` wait cycles, check the completion.
    task automatic serve(input int delay, input int exp_lat, input bit drop);
        exp_t        e;
        int          lat;
        logic [31:0] a0;
        logic        w0;
        logic [31:0] wd0;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard underflow");
            $fatal(1, "scoreboard underflow");
        end
        e   = sb.pop_front();
        lat = 0;
        while (!mem_req && lat < 20) begin
            tick();
            lat++;
        end
        chk("mem_req_seen", {63'd0, mem_req}, 64'd1);
        if (!mem_req) return;
        chk("grant_latency", 64'(lat), 64'(exp_lat));
        chk("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
        chk("mem_we", {63'd0, mem_we}, {63'd0, e.we});
        if (e.we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
        a0  = mem_addr;
        w0  = mem_we;
        wd0 = mem_wdata;
        for (int k = 0; k < delay; k++) begin
            tick();
            chk("mem_req_hold", {63'd0, mem_req}, 64'd1);
            chk("mem_addr_hold", {32'd0, mem_addr}, {32'd0, a0});
            chk("mem_we_hold", {63'd0, mem_we}, {63'd0, w0});
            chk("mem_wdata_hold", {32'd0, mem_wdata}, {32'd0, wd0});
            chk("no_early_valid", {62'd0, i_valid, d_valid}, 64'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = e.rdata;
        tick();
        mem_ack = 1'b0;
        if (!e.port_d) exp_i_rdata = e.rdata;
        else if (!e.we) exp_d_rdata = e.rdata;
        chk("i_valid_pulse", {63'd0, i_valid}, {63'd0, !e.port_d});
        chk("d_valid_pulse", {63'd0, d_valid}, {63'd0, e.port_d});
        chk("mem_req_drop", {63'd0, mem_req}, 64'd0);
        chk("i_rdata", {32'd0, i_rdata}, {32'd0, exp_i_rdata});
        chk("d_rdata", {32'd0, d_rdata}, {32'd0, exp_d_rdata});
        if (drop) begin
            if (e.port_d) d_req = 1'b0;
            else i_req = 1'b0;
        end
        tick();
        chk("valid_one_cycle", {62'd0, i_valid, d_valid}, 64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        i_req     = 1'b1;
        d_req     = 1'b1;
        d_we      = 1'b0;
        i_addr    = 32'h80;
        d_addr    = 32'h40;
        d_wdata   = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;

        tick();
        tick();
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_valids", {62'd0, i_valid, d_valid}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_i_rdata", {32'd0, i_rdata}, 64'd0);
        chk("rst_d_rdata", {32'd0, d_rdata}, 64'd0);

        rst = 1'b1;
        push(1'b1, 32'h40, 1'b0, 32'h0, 32'h0A0A0A0A);
        push(1'b0, 32'h80, 1'b0, 32'h0, 32'h0B0B0B0B);
        serve(0, 1, 1'b1);
        serve(0, 1, 1'b1);

        i_addr = 32'h100;
        i_req  = 1'b1;
        push(1'b0, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF);
        serve(0, 1, 1'b1);

        d_we    = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 32'h12345678;
        d_req   = 1'b1;
        push(1'b1, 32'h200, 1'b1, 32'h12345678, 32'hBAD0BAD0);
        serve(5, 1, 1'b1);
        d_we = 1'b0;

        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        tick();
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_req", {63'd0, mem_req}, 64'd0);
        chk("stray_ack_valid", {62'd0, i_valid, d_valid}, 64'd0);
        chk("stray_ack_i_rdata", {32'd0, i_rdata}, {32'd0, exp_i_rdata});
        chk("stray_ack_d_rdata", {32'd0, d_rdata}, {32'd0, exp_d_rdata});

        i_addr = 32'h110;
        d_addr = 32'h210;
        i_req  = 1'b1;
        d_req  = 1'b1;
        push(1'b1, 32'h210, 1'b0, 32'h0, 32'h11112222);
        push(1'b0, 32'h110, 1'b0, 32'h0, 32'h33334444);
        serve(0, 1, 1'b1);
        serve(0, 1, 1'b1);

        d_addr = 32'h220;
        d_req  = 1'b1;
        tick();
        chk("midrst_busy", {63'd0, mem_req}, 64'd1);
        chk("midrst_addr", {32'd0, mem_addr}, 64'h220);
        rst   = 1'b0;
        d_req = 1'b0;
        tick();
        chk("midrst_req_clr", {63'd0, mem_req}, 64'd0);
        rst = 1'b1;
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        tick();
        mem_ack = 1'b0;
        chk("midrst_no_valid", {62'd0, i_valid, d_valid}, 64'd0);
        chk("midrst_d_rdata", {32'd0, d_rdata}, 64'd0);
        tick();
        chk("midrst_idle_req", {63'd0, mem_req}, 64'd0);
        chk("midrst_no_valid2", {62'd0, i_valid, d_valid}, 64'd0);
        i_addr = 32'h120;
        i_req  = 1'b1;
        push(1'b0, 32'h120, 1'b0, 32'h0, 32'hCAFEF00D);
        serve(0, 1, 1'b1);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;
        i_addr = 32'h300;
        d_addr = 32'h400;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            if ((k % 5) == 4) push(1'b0, 32'h300, 1'b0, 32'h0, 32'h9000_0000 + 32'(k));
            else push(1'b1, 32'h400, 1'b0, 32'h0, 32'h9000_0000 + 32'(k));
`else
            push(1'b1, 32'h400, 1'b0, 32'h0, 32'h9000_0000 + 32'(k));
`endif
        end
        for (int k = 0; k < 10; k++) begin
            serve(0, 1, 1'b0);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        chk("final_idle", {63'd0, mem_req}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
